desc_window_scan: RTL and testbench

- Upstream driver of the per-direction rotated-coordinate ROM pair used in the SIFT descriptor stage.
- On start, walks the 16x16 sample window around a keypoint, row-major, one address per accepted cycle.
- Presents each address to the x/y rotation ROMs and range-checks the returned signed rotated coordinates.
- Emits a per-sample stream (window row/col plus 4x4 descriptor cell index) to the histogram accumulator over a valid/ready handshake.

---
 rtl/desc_window_scan_if.sv | 27 ++
 rtl/desc_window_scan.sv | 182 ++++++++++++++++++
 tb/tb_desc_window_scan.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/desc_window_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : desc_window_scan_if
//  Brief    : Sample stream from the descriptor window scanner to the
//             histogram accumulator (valid/ready, one sample per beat).
//  Revision : 1.0  initial release
// ============================================================================
interface desc_window_scan_if;
    logic       smp_valid;
    logic       smp_ready;
    logic [3:0] smp_row;
    logic [3:0] smp_col;
    logic [1:0] smp_cx;
    logic [1:0] smp_cy;
    logic       smp_in;

    modport master (
        output smp_valid, smp_row, smp_col, smp_cx, smp_cy, smp_in,
        input  smp_ready
    );

    modport slave (
        input  smp_valid, smp_row, smp_col, smp_cx, smp_cy, smp_in,
        output smp_ready
    );
endinterface
`default_nettype wire

// File: rtl/desc_window_scan.sv
`default_nettype none
// ============================================================================
//  Module   : desc_window_scan
//  Brief    : Walks the 16x16 keypoint window row-major, drives the rotated
//             coordinate ROM pair, range-checks the rotated coordinates and
//             emits per-sample cell indices over a valid/ready stream.
//  Revision : 1.0  initial release
// ============================================================================
module desc_window_scan #(
    parameter bit DROP_OUT = 1'b1,
    parameter int CW       = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [7:0]          rom_addr,
    input  logic [CW-1:0]       rom_x,
    input  logic [CW-1:0]       rom_y,
    desc_window_scan_if.master  smp,
    output logic [8:0]          in_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Offset that maps the window range -8..7 onto 0..15, and the top of it.
    localparam logic signed [CW:0] c_OFS = (CW+1)'(8);
    localparam logic signed [CW:0] c_MAX = (CW+1)'(15);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [7:0]         r_addr;
    logic               r_busy;
    logic               r_done;
    logic               r_valid;
    logic [3:0]         r_row;
    logic [3:0]         r_col;
    logic [1:0]         r_cx;
    logic [1:0]         r_cy;
    logic               r_in;
    logic [8:0]         r_cnt;
    logic [8:0]         r_in_count;

    logic               w_adv;
    logic               w_accept;
    logic               w_capture;
    logic               w_finish;
    logic               w_emit;
    logic               w_in;
    logic               w_in_x;
    logic               w_in_y;
    logic signed [CW:0] w_xo;
    logic signed [CW:0] w_yo;

    // The output register may take a new sample when empty or being drained.
    assign w_adv = !r_valid || smp.smp_ready;

    // Shift coordinates by +8 one bit wider than the ROM word so the sum
    // cannot wrap; inside the window the result is exactly 0..15.
    assign w_xo   = $signed({rom_x[CW-1], rom_x}) + c_OFS;
    assign w_yo   = $signed({rom_y[CW-1], rom_y}) + c_OFS;
    assign w_in_x = !w_xo[CW] && (w_xo <= c_MAX);
    assign w_in_y = !w_yo[CW] && (w_yo <= c_MAX);
    assign w_in   = w_in_x && w_in_y;

    generate
        if (DROP_OUT) begin : g_drop
            assign w_emit = w_in;
        end else begin : g_keep
            assign w_emit = 1'b1;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and step strobes. A start seen while done is still high
    // belongs to the finishing scan and is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !r_done) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_adv) begin
                    w_capture = 1'b1;
                    if (r_addr == 8'hFF) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_adv) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address walk, output sample register, in-window counting and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_row      <= 4'd0;
            r_col      <= 4'd0;
            r_cx       <= 2'd0;
            r_cy       <= 2'd0;
            r_in       <= 1'b0;
            r_cnt      <= 9'd0;
            r_in_count <= 9'd0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_busy <= 1'b1;
                r_addr <= 8'd0;
                r_cnt  <= 9'd0;
            end
            if (w_capture) begin
                r_addr <= r_addr + 8'd1;
                if (w_in) begin
                    r_cnt <= r_cnt + 9'd1;
                end
                if (w_emit) begin
                    r_valid <= 1'b1;
                    r_row   <= r_addr[7:4];
                    r_col   <= r_addr[3:0];
                    r_cx    <= w_in ? w_xo[3:2] : 2'd0;
                    r_cy    <= w_in ? w_yo[3:2] : 2'd0;
                    r_in    <= w_in;
                end else begin
                    // Dropped sample: fields hold, address still advances.
                    r_valid <= 1'b0;
                end
            end
            if (w_finish) begin
                r_valid    <= 1'b0;
                r_done     <= 1'b1;
                r_busy     <= 1'b0;
                r_in_count <= r_cnt;
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign rom_addr      = r_addr;
    assign in_count      = r_in_count;
    assign smp.smp_valid = r_valid;
    assign smp.smp_row   = r_row;
    assign smp.smp_col   = r_col;
    assign smp.smp_cx    = r_cx;
    assign smp.smp_cy    = r_cy;
    assign smp.smp_in    = r_in;

endmodule
`default_nettype wire

// File: tb/tb_desc_window_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_desc_window_scan
//  Brief    : Bench for desc_window_scan; one instance with DROP_OUT=0
//             (index 0) and one with DROP_OUT=1 (index 1) share stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_desc_window_scan;

    localparam int c_CW = 5;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
        logic [1:0] cx;
        logic [1:0] cy;
        logic       inw;
    } smp_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic ready = 1'b0;

    int rom_mode  = 0;
    int rdy_mode  = 0;
    int cyc       = 0;
    int n_err     = 0;
    int n_chk     = 0;
    int exp_in    = 0;
    int start_cyc = 0;
    int scan_id   = 0;
    bit chk_en    = 1'b0;

    logic [1:0]      busy_a;
    logic [1:0]      done_a;
    logic [1:0]      val_a;
    logic [7:0]      addr_a [2];
    logic [c_CW-1:0] rx_a   [2];
    logic [c_CW-1:0] ry_a   [2];
    logic [8:0]      inc_a  [2];
    smp_t            smp_a  [2];

    smp_t q0[$];
    smp_t q1[$];

    int   done_cnt [2];
    int   done_cyc [2];
    int   seen_id  [2];
    smp_t first_s  [2];
    smp_t hold_s   [2];
    bit   hold_v   [2];

    desc_window_scan_if if_keep ();
    desc_window_scan_if if_drop ();

    // ROM contents per test mode.
    function automatic logic [c_CW-1:0] rom_x_f(input int mode, input logic [7:0] a);
        case (mode)
            0:       return 5'h1F;
            1:       return (a < 8'd128) ? 5'h16 : 5'h07;
            default: return 5'(a * 3);
        endcase
    endfunction

    function automatic logic [c_CW-1:0] rom_y_f(input int mode, input logic [7:0] a);
        case (mode)
            0:       return 5'h00;
            1:       return (a < 8'd128) ? 5'h00 : 5'h18;
            default: return 5'(a >> 3);
        endcase
    endfunction

    assign rx_a[0] = rom_x_f(rom_mode, addr_a[0]);
    assign ry_a[0] = rom_y_f(rom_mode, addr_a[0]);
    assign rx_a[1] = rom_x_f(rom_mode, addr_a[1]);
    assign ry_a[1] = rom_y_f(rom_mode, addr_a[1]);

    assign if_keep.smp_ready = ready;
    assign if_drop.smp_ready = ready;
    assign val_a[0] = if_keep.smp_valid;
    assign val_a[1] = if_drop.smp_valid;
    assign smp_a[0] = {if_keep.smp_row, if_keep.smp_col, if_keep.smp_cx, if_keep.smp_cy, if_keep.smp_in};
    assign smp_a[1] = {if_drop.smp_row, if_drop.smp_col, if_drop.smp_cx, if_drop.smp_cy, if_drop.smp_in};

    desc_window_scan #(.DROP_OUT(1'b0), .CW(c_CW)) u_keep (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy_a[0]),
        .done     (done_a[0]),
        .rom_addr (addr_a[0]),
        .rom_x    (rx_a[0]),
        .rom_y    (ry_a[0]),
        .smp      (if_keep),
        .in_count (inc_a[0])
    );

    desc_window_scan #(.DROP_OUT(1'b1), .CW(c_CW)) u_drop (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy_a[1]),
        .done     (done_a[1]),
        .rom_addr (addr_a[1]),
        .rom_x    (rx_a[1]),
        .rom_y    (ry_a[1]),
        .smp      (if_drop),
        .in_count (inc_a[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready pattern: 0 = always, 1 = toggle, 2 = random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       ready = 1'b1;
                1:       ready = ~ready;
                default: ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference stream: window sample decoded straight from the ROM values.
    function automatic smp_t model_smp(input int mode, input int a);
        int   xi;
        int   yi;
        bit   inw;
        smp_t s;
        xi    = $signed(rom_x_f(mode, 8'(a)));
        yi    = $signed(rom_y_f(mode, 8'(a)));
        inw   = (xi >= -8) && (xi <= 7) && (yi >= -8) && (yi <= 7);
        s.row = 4'(a / 16);
        s.col = 4'(a % 16);
        s.inw = inw;
        s.cx  = inw ? 2'((xi + 8) / 4) : 2'd0;
        s.cy  = inw ? 2'((yi + 8) / 4) : 2'd0;
        return s;
    endfunction

    task automatic build_expected(input int mode);
        smp_t s;
        rom_mode = mode;
        q0.delete();
        q1.delete();
        exp_in = 0;
        for (int a = 0; a < 256; a++) begin
            s = model_smp(mode, a);
            q0.push_back(s);
            if (s.inw) begin
                q1.push_back(s);
                exp_in++;
            end
        end
        scan_id++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int t0, input int t1, input int budget, input string nm);
        int k;
        k = 0;
        while ((done_cnt[0] < t0 || done_cnt[1] < t1) && k < budget) begin
            tick(1);
            k++;
        end
        n_chk++;
        if (done_cnt[0] < t0 || done_cnt[1] < t1) begin
            n_err++;
            $display("FAIL %s_timeout: done counts %0d/%0d expected %0d/%0d", nm, done_cnt[0], done_cnt[1], t0, t1);
        end
    endtask

    task automatic check_reset(input string nm);
        @(negedge clk);
        chk({nm, "_busy_done"}, {busy_a, done_a}, 0);
        chk({nm, "_rom_addr"}, {addr_a[0], addr_a[1]}, 0);
        chk({nm, "_valid"}, val_a, 0);
        chk({nm, "_fields"}, {smp_a[0], smp_a[1]}, 0);
        chk({nm, "_in_count"}, {inc_a[0], inc_a[1]}, 0);
    endtask

    // Scoreboard: every handshake, stall stability and every done pulse.
    always @(negedge clk) begin
        smp_t e;
        bit   have;
        for (int i = 0; i < 2; i++) begin
            if (done_a[i]) begin
                done_cnt[i] = done_cnt[i] + 1;
                done_cyc[i] = cyc;
            end
            if (chk_en) begin
                if (hold_v[i]) begin
                    n_chk++;
                    if (!(val_a[i] && smp_a[i] == hold_s[i])) begin
                        n_err++;
                        $display("FAIL stall_hold dut%0d: valid=%0b fields=%h required valid=1 fields=%h", i, val_a[i], smp_a[i], hold_s[i]);
                    end
                end
                hold_v[i] = val_a[i] && !ready;
                hold_s[i] = smp_a[i];
                if (val_a[i] && ready) begin
                    have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    n_chk++;
                    if (!have) begin
                        n_err++;
                        $display("FAIL extra_sample dut%0d: got %h expected none", i, smp_a[i]);
                    end else begin
                        if (i == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        if (smp_a[i] !== e) begin
                            n_err++;
                            $display("FAIL sample dut%0d: got %h expected %h", i, smp_a[i], e);
                        end
                    end
                    if (seen_id[i] != scan_id) begin
                        seen_id[i] = scan_id;
                        first_s[i] = smp_a[i];
                    end
                end
                if (done_a[i]) begin
                    have = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
                    n_chk++;
                    if (!(have && inc_a[i] == 9'(exp_in) && !busy_a[i])) begin
                        n_err++;
                        $display("FAIL done dut%0d: in_count=%0d busy=%0b left=%0d expected in_count=%0d busy=0 left=0",
                                 i, inc_a[i], busy_a[i], (i == 0) ? q0.size() : q1.size(), exp_in);
                    end
                end
            end else begin
                hold_v[i] = 1'b0;
            end
        end
    end

    initial begin
        int b0;
        int b1;
        int lat;
        for (int i = 0; i < 2; i++) begin
            done_cnt[i] = 0;
            seen_id[i]  = 0;
        end

        // Power-on reset.
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        check_reset("reset_init");
        tick(1);

        // A: every sample inside, continuous ready.
        rdy_mode = 0;
        build_expected(0);
        chk("modelA_in", exp_in, 256);
        chk("modelA_first", q1[0], {4'd0, 4'd0, 2'd1, 2'd2, 1'b1});
        chk_en = 1'b1;
        b0 = done_cnt[0];
        b1 = done_cnt[1];
        tick(2);
        pulse_start();
        chk("A_busy", busy_a, 2'b11);
        wait_done(b0 + 1, b1 + 1, 400, "A");
        chk("A_latency", done_cyc[0] - start_cyc, 257);
        chk("A_in_count", inc_a[1], 256);
        chk("A_first_dut", first_s[1], {4'd0, 4'd0, 2'd1, 2'd2, 1'b1});

        // B: first half out of range in x, second half at the window corner.
        build_expected(1);
        chk("modelB_in", exp_in, 128);
        chk("modelB_len", {16'(q0.size()), 16'(q1.size())}, {16'd256, 16'd128});
        chk("modelB_first", q1[0], {4'd8, 4'd0, 2'd3, 2'd0, 1'b1});
        b0 = done_cnt[0];
        b1 = done_cnt[1];
        tick(2);
        pulse_start();
        wait_done(b0 + 1, b1 + 1, 400, "B");
        chk("B_in_count", {inc_a[0], inc_a[1]}, {9'd128, 9'd128});
        chk("B_first_drop", first_s[1], {4'd8, 4'd0, 2'd3, 2'd0, 1'b1});
        chk("B_first_keep", first_s[0], 0);

        // C: mixed coordinates, ready toggling every cycle.
        build_expected(2);
        chk("modelC_s2", q0[2], {4'd0, 4'd2, 2'd3, 2'd2, 1'b1});
        chk("modelC_s3", q0[3], {4'd0, 4'd3, 2'd0, 2'd0, 1'b0});
        rdy_mode = 1;
        b0 = done_cnt[0];
        b1 = done_cnt[1];
        tick(2);
        pulse_start();
        wait_done(b0 + 1, b1 + 1, 1200, "C");
        lat = done_cyc[0] - start_cyc;
        n_chk++;
        if (lat < 511 || lat > 513) begin
            n_err++;
            $display("FAIL C_latency: got %0d expected 511..513", lat);
        end

        // D: reset 40 cycles into a scan, then a fresh scan.
        rdy_mode = 2;
        build_expected(2);
        tick(2);
        pulse_start();
        tick(40);
        chk_en = 1'b0;
        b0 = done_cnt[0] + done_cnt[1];
        rst = 1'b1;
        tick(1);
        check_reset("D_reset");
        rst = 1'b0;
        tick(5);
        chk("D_no_done", done_cnt[0] + done_cnt[1], b0);
        build_expected(2);
        chk_en = 1'b1;
        b0 = done_cnt[0];
        b1 = done_cnt[1];
        pulse_start();
        wait_done(b0 + 1, b1 + 1, 1500, "D");
        chk("D_first_keep", first_s[0], {4'd0, 4'd0, 2'd2, 2'd2, 1'b1});
        chk("D_in_count", inc_a[0], 9'(exp_in));

        // E: start pulsed mid-scan and again in the done cycle.
        rdy_mode = 0;
        build_expected(0);
        b0 = done_cnt[0];
        b1 = done_cnt[1];
        tick(2);
        pulse_start();
        tick(20);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        while (cyc < start_cyc + 257) tick(1);
        chk("E_done_cycle", done_a, 2'b11);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(300);
        chk("E_done_count", {16'(done_cnt[0] - b0), 16'(done_cnt[1] - b1)}, {16'd1, 16'd1});
        chk("E_idle", {busy_a, val_a}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
